// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle around the instruction prefetch queue.
// master: the fetch + decode side (drives push data and pop_ready).
// slave:  the queue itself.
interface instr_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // fetch -> queue
    logic             push_valid;
    logic [WIDTH-1:0] instr_in;
    logic [WIDTH-1:0] pc_plus_4_in;
    logic             push_ready;

    // queue -> decode
    logic             pop_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] instr_out;
    logic [WIDTH-1:0] pc_plus_4_out;

    // occupancy
    logic [CNT_W-1:0] count;

    modport master (
        output push_valid,
        output instr_in,
        output pc_plus_4_in,
        input  push_ready,
        output pop_ready,
        input  pop_valid,
        input  instr_out,
        input  pc_plus_4_out,
        input  count
    );

    modport slave (
        input  push_valid,
        input  instr_in,
        input  pc_plus_4_in,
        output push_ready,
        input  pop_ready,
        output pop_valid,
        output instr_out,
        output pc_plus_4_out,
        output count
    );
endinterface

// File: rtl/instr_queue.sv
// Instruction prefetch queue between fetch and the decode register.
// Buffers {instr, pc_plus_4} pairs in order; head is first-word fall-through.
// A flush (branch/jump redirect) empties the queue on the same edge.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    instr_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc_plus_4;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full;
    logic             empty;
    logic             push_acc;
    logic             pop_acc;

    // Handshake qualification: both flags come from registered count only.
    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        push_acc = bus.push_valid && !full;
        pop_acc  = bus.pop_ready && !empty;
    end

    // Next-state for storage, pointers and occupancy; flush overrides any push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                mem_d[wr_ptr_q] = '{instr: bus.instr_in, pc_plus_4: bus.pc_plus_4_in};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care after reset so no reset term.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head fall-through; an empty queue presents a nop with zero PC+4.
    always_comb begin
        bus.push_ready    = !full;
        bus.pop_valid     = !empty;
        bus.count         = count_q;
        bus.instr_out     = '0;
        bus.pc_plus_4_out = '0;
        if (!empty) begin
            bus.instr_out     = mem_q[rd_ptr_q].instr;
            bus.pc_plus_4_out = mem_q[rd_ptr_q].pc_plus_4;
        end
    end
endmodule
